pool_engine: RTL and testbench

Parametrised multi-channel pooling engine that succeeds the single-lane max-pool unit used after the convolution layers. It reduces each run of WIN consecutive accepted samples per channel to one result, selectable as max or average, signed or unsigned. Results are delivered through valid/ready handshakes on both sides, so the engine sits directly between the conv output stream and the next layer's input buffer.

---
 rtl/pool_pkg.sv | 19 +
 rtl/pool_lane.sv | 65 ++++++
 rtl/pool_engine.sv | 109 ++++++++++
 tb/tb_pool_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pool_pkg : shared pooling mode encodings and width helper        |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package pool_pkg;

   localparam logic POOL_MAX = 1'b0;
   localparam logic POOL_AVG = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pool_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pool_lane : one channel of max/average pooling accumulation      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pool_lane
   import pool_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int WIN    = 4,
   parameter int SIGNED = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              first,
   input  logic              last,
   input  logic              mode,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] result
);

   localparam int LW    = clog2(WIN);
   localparam int ACC_W = DATA_W + LW;

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_new;
   logic [ACC_W-1:0] sample_ext;
   logic             take;

   always_comb begin
      // Max mode stores the extended sample too; extension preserves ordering.
      sample_ext = (SIGNED != 0) ? {{LW{sample[DATA_W-1]}}, sample}
                                 : {{LW{1'b0}}, sample};
      take       = (SIGNED != 0) ? ($signed(sample_ext) > $signed(acc_q))
                                 : (sample_ext > acc_q);

      if (first)
         acc_new = sample_ext;
      else if (mode == POOL_AVG)
         acc_new = acc_q + sample_ext;
      else
         acc_new = take ? sample_ext : acc_q;

      acc_d = acc_q;
      if (clr || (en && last))
         acc_d = '0;
      else if (en)
         acc_d = acc_new;

      // Upper slice of the sum is the floor shift for both signednesses.
      result = (mode == POOL_AVG) ? acc_new[LW +: DATA_W] : acc_new[DATA_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

endmodule
`default_nettype wire

// File: rtl/pool_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pool_engine : multi-channel windowed max/average pooling engine  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pool_engine
   import pool_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CH     = 4,
   parameter int WIN    = 4,
   parameter int SIGNED = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pool_mode,
   input  logic                 pool_clr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH*DATA_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH*DATA_W-1:0] out_data,
   output logic                 win_busy
);

   localparam int LW = clog2(WIN);

   if ((WIN < 2) || (WIN > 64) || ((1 << LW) != WIN)) begin : g_win_check
      $error("pool_engine: WIN must be a power of 2 in 2..64");
   end

   logic [LW-1:0]          count_q, count_d;
   logic                   mode_q, mode_d;
   logic                   out_valid_q, out_valid_d;
   logic [CH*DATA_W-1:0]   out_data_q, out_data_d;
   logic [CH*DATA_W-1:0]   lane_result;
   logic                   accept;
   logic                   first;
   logic                   last;
   logic                   lane_mode;

   always_comb begin
      in_ready  = !out_valid_q || out_ready;
      accept    = in_valid && in_ready && !pool_clr;
      first     = (count_q == '0);
      last      = (count_q == LW'(WIN - 1));
      lane_mode = first ? pool_mode : mode_q;

      count_d     = count_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      // Abort wins over accept; the output register is left alone.
      if (pool_clr) begin
         count_d = '0;
      end else if (accept) begin
         count_d = count_q + 1'b1;
         if (first)
            mode_d = pool_mode;
         if (last) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_result;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         mode_q      <= POOL_MAX;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         count_q     <= count_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_lane
      pool_lane #(
         .DATA_W (DATA_W),
         .WIN    (WIN),
         .SIGNED (SIGNED)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (accept),
         .clr    (pool_clr),
         .first  (first),
         .last   (last),
         .mode   (lane_mode),
         .sample (in_data[k*DATA_W +: DATA_W]),
         .result (lane_result[k*DATA_W +: DATA_W])
      );
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign win_busy  = (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_pool_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pool_engine : scoreboard bench, signed CH=4 and unsigned CH=1 |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_pool_engine;

   localparam int DW  = 16;
   localparam int CH  = 4;
   localparam int WIN = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              pool_mode;
   logic              pool_clr;
   logic              in_valid;
   logic              out_ready;
   logic [CH*DW-1:0]  in_data;
   logic              in_ready, out_valid, win_busy;
   logic [CH*DW-1:0]  out_data;
   logic              in_ready_u, out_valid_u, win_busy_u;
   logic [DW-1:0]     out_data_u;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pool_engine #(.DATA_W(DW), .CH(CH), .WIN(WIN), .SIGNED(1)) u_dut (
      .clk(clk), .rst(rst), .pool_mode(pool_mode), .pool_clr(pool_clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .win_busy(win_busy)
   );

   pool_engine #(.DATA_W(DW), .CH(1), .WIN(WIN), .SIGNED(0)) u_dut_u (
      .clk(clk), .rst(rst), .pool_mode(pool_mode), .pool_clr(pool_clr),
      .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data[DW-1:0]),
      .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
      .win_busy(win_busy_u)
   );

   typedef struct {
      logic [CH*DW-1:0] d;
      logic [DW-1:0]    du;
   } exp_t;

   exp_t             exp_q[$];
   logic [CH*DW-1:0] beats[$];
   logic             m_mode;
   longint           last_push = -100;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int fdiv(input int s, input int w);
      int q;
      q = s / w;
      if ((s % w != 0) && (s < 0)) q--;
      return q;
   endfunction

   // Reference: max or floor(mean) over the collected window, plain integers.
   function automatic exp_t ref_result();
      exp_t e;
      int   r;
      for (int k = 0; k < CH; k++) begin
         int best, sum;
         logic signed [DW-1:0] sv;
         sum = 0;
         for (int i = 0; i < WIN; i++) begin
            int v;
            sv = beats[i][k*DW +: DW];
            v  = sv;
            sum += v;
            if (i == 0 || v > best) best = v;
         end
         r = m_mode ? fdiv(sum, WIN) : best;
         e.d[k*DW +: DW] = r[DW-1:0];
      end
      begin
         int best, sum;
         sum = 0;
         for (int i = 0; i < WIN; i++) begin
            int v;
            v = beats[i][DW-1:0];
            sum += v;
            if (i == 0 || v > best) best = v;
         end
         r = m_mode ? (sum / WIN) : best;
         e.du = r[DW-1:0];
      end
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         beats.delete();
         exp_q.delete();
      end else if (pool_clr) begin
         beats.delete();
      end else if (in_valid && in_ready) begin
         if (beats.size() == 0) m_mode = pool_mode;
         beats.push_back(in_data);
         if (beats.size() == WIN) begin
            exp_q.push_back(ref_result());
            beats.delete();
            last_push = $time;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, !out_valid || out_ready);
         chk("in_ready_u", in_ready_u, !out_valid_u || out_ready);
         chk("valid_u", out_valid_u, out_valid);
         chk("win_busy", win_busy, beats.size() != 0);
         chk("win_busy_u", win_busy_u, beats.size() != 0);
         if ($time - last_push == 5) chk("latency", out_valid, 1);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", out_valid, 0);
            end else begin
               chk("out_data", out_data, exp_q[0].d);
               chk("out_data_u", out_data_u, exp_q[0].du);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [DW-1:0] l0, input logic m, input bit rnd);
      int n;
      bit acc;
      n   = 0;
      acc = 0;
      in_valid  = 1'b1;
      pool_mode = m;
      in_data   = {$urandom, $urandom};
      in_data[DW-1:0] = l0;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         n++;
         if (!acc && n > 200) begin
            chk("send_timeout", in_ready, 1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_pulse(input logic with_beat);
      pool_clr = 1'b1;
      in_valid = with_beat;
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      pool_clr = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pool_mode = 1'b0; pool_clr = 1'b0; in_valid = 1'b0;
      out_ready = 1'b1; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_win_busy", win_busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data_u", out_data_u, 0);
      rst = 1'b0;
      idle(2);

      // max 3,9,2,7 -> 9; avg -1..-4 -> -3; avg 5..8 -> 6
      send(16'd3, 0, 0); send(16'd9, 0, 0); send(16'd2, 0, 0); send(16'd7, 0, 0);
      send(16'hFFFF, 1, 0); send(16'hFFFE, 1, 0); send(16'hFFFD, 1, 0); send(16'hFFFC, 1, 0);
      send(16'd5, 1, 0); send(16'd6, 1, 0); send(16'd7, 1, 0); send(16'd8, 1, 0);
      idle(2);

      // backpressure: result held, input stalled for 10 cycles
      out_ready = 1'b0;
      send(16'd100, 0, 0); send(16'd50, 0, 0); send(16'd75, 0, 0); send(16'd25, 0, 0);
      in_valid = 1'b1; pool_mode = 1'b0; in_data = {$urandom, $urandom};
      repeat (10) @(posedge clk);
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      send(16'd1, 0, 0); send(16'd2, 0, 0); send(16'd3, 0, 0);
      idle(2);

      // clear with a pending result, then a discarded partial window
      out_ready = 1'b0;
      send(16'd11, 0, 0); send(16'd12, 0, 0); send(16'd13, 0, 0); send(16'd14, 0, 0);
      clr_pulse(1'b1);
      idle(3);
      out_ready = 1'b1;
      idle(1);
      send(16'd10, 0, 0); send(16'd20, 0, 0);
      clr_pulse(1'b1);
      chk("clr_win_busy", win_busy, 0);
      send(16'd1, 0, 0); send(16'd2, 0, 0); send(16'd3, 0, 0); send(16'd4, 0, 0);
      idle(2);

      // mode flips mid-window are ignored
      send(16'd1, 0, 0); send(16'd8, 1, 0); send(16'd3, 1, 0); send(16'd2, 0, 0);
      send(16'd4, 1, 0); send(16'd4, 1, 0); send(16'd8, 0, 0); send(16'd8, 0, 0);
      idle(2);

      // reset mid-window
      send(16'd30, 0, 0); send(16'd31, 0, 0); send(16'd32, 0, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_win_busy", win_busy, 0);
      chk("mid_rst_out_data", out_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      send(16'd5, 0, 0); send(16'd1, 0, 0); send(16'd2, 0, 0); send(16'd3, 0, 0);
      idle(2);

      // randomized traffic
      for (int it = 0; it < 400; it++) begin
         int sel;
         sel = $urandom_range(0, 15);
         if (sel == 0)
            clr_pulse(logic'($urandom_range(0, 1)));
         else if (sel < 3)
            idle($urandom_range(1, 3));
         else
            send(16'($urandom), logic'($urandom_range(0, 1)), 1);
      end

      out_ready = 1'b1;
      idle(5);
      chk("drain_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
